framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_writer.sv | 117 +++++++++++
 tb/tb_framebuffer_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// UART byte-stream to framebuffer writer: parses full-frame and windowed
// write commands and streams payload bytes into a 4 KiB byte RAM.
module framebuffer_writer #(
  parameter int TIMEOUT_CYCLES = 53200,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_HI = 3'd1;
  localparam logic [2:0] ADDR_LO = 3'd2;
  localparam logic [2:0] LEN_HI  = 3'd3;
  localparam logic [2:0] LEN_LO  = 3'd4;
  localparam logic [2:0] DATA    = 3'd5;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]               state;
  logic [11:0]              addr;
  logic [12:0]              remaining;
  logic [3:0]               len_hi;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic [11:0]              len;

  assign len = {len_hi, rx_data};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      len_hi     <= '0;
      timer      <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wr     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      ram_wr     <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      // An arriving byte always beats a timeout landing on the same edge.
      if (rx_valid) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (rx_data == 8'h01) begin
              addr      <= '0;
              remaining <= 13'd4096;
              state     <= DATA;
              busy      <= 1'b1;
            end else if (rx_data == 8'h02) begin
              state <= ADDR_HI;
              busy  <= 1'b1;
            end
          end
          ADDR_HI: begin
            addr[11:8] <= rx_data[3:0];
            state      <= ADDR_LO;
          end
          ADDR_LO: begin
            addr[7:0] <= rx_data;
            state     <= LEN_HI;
          end
          LEN_HI: begin
            len_hi <= rx_data[3:0];
            state  <= LEN_LO;
          end
          LEN_LO: begin
            // A zero length encodes a full 4096-byte window.
            remaining <= (len == 12'd0) ? 13'd4096 : {1'b0, len};
            state     <= DATA;
          end
          DATA: begin
            ram_wr    <= 1'b1;
            ram_addr  <= addr;
            ram_data  <= rx_data;
            addr      <= addr + 12'd1;
            remaining <= remaining - 13'd1;
            if (remaining == 13'd1) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        if (timer == TIMER_LAST) begin
          error <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: expected writes are queued by
// the stimulus and popped by a negedge monitor whenever ram_wr is seen.
module tb_framebuffer_writer;

  localparam int TO = 60;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        done;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wr;
  logic        busy;
  logic        frame_done;
  logic        error;

  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  n_done = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  framebuffer_writer #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_WIDTH(16)
  ) dut (
    .clk_in(clk),
    .reset(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wr(ram_wr),
    .busy(busy),
    .frame_done(frame_done),
    .error(error)
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input int d, input bit dn);
    wr_t w;
    w.addr = 12'(a);
    w.data = 8'(d);
    w.done = dn;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (error) n_err++;
    if (frame_done) n_done++;
    if (ram_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {20'h0, ram_addr}, 0);
      end else begin
        w = exp_q.pop_front();
        if (ram_addr != w.addr)
          chk("wr_addr", int'(ram_addr), int'(w.addr));
        if (ram_data != w.data)
          chk("wr_data", int'(ram_data), int'(w.data));
        chk("wr_done", int'(frame_done), int'(w.done));
      end
    end else if (frame_done) begin
      chk("done_without_wr", 1, 0);
    end
  end

  initial begin
    #2;
    chk("rst_wr", int'(ram_wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    chk("rst_pulses", int'({frame_done, error}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Junk bytes are ignored, then a full-frame command streams 4096 bytes.
    send(8'h55);
    send(8'h7F);
    chk("junk_busy", int'(busy), 0);
    send(8'h01);
    chk("cmd1_busy", int'(busy), 1);
    for (int i = 0; i < 4096; i++) begin
      expect_wr(i, i & 8'hFF, i == 4095);
      send(8'(i));
    end
    gap(2);
    chk("full_done", n_done, 1);
    chk("full_busy", int'(busy), 0);
    chk("full_q", exp_q.size(), 0);

    // Windowed write wrapping the 4 KiB address space.
    expect_wr(12'hFFE, 8'hAA, 0);
    expect_wr(12'hFFF, 8'hBB, 0);
    expect_wr(12'h000, 8'hCC, 1);
    send(8'h02); send(8'h0F); send(8'hFE);
    send(8'h00); send(8'h03);
    gap(2);
    send(8'hAA); send(8'hBB); send(8'hCC);
    gap(2);
    chk("wrap_done", n_done, 2);
    chk("wrap_busy", int'(busy), 0);
    chk("wrap_q", exp_q.size(), 0);

    // Silence after 10 bytes aborts with a single error pulse.
    send(8'h01);
    for (int i = 0; i < 10; i++) begin
      expect_wr(i, 8'h30 + i, 0);
      send(8'(8'h30 + i));
    end
    gap(TO + 10);
    chk("to_err", n_err, 1);
    chk("to_done", n_done, 2);
    chk("to_busy", int'(busy), 0);
    chk("to_q", exp_q.size(), 0);

    // A byte on the exact timeout edge still counts and clears the timer.
    expect_wr(12'h020, 8'h11, 0);
    expect_wr(12'h021, 8'h22, 1);
    send(8'h02); send(8'h00); send(8'h20);
    send(8'h00); send(8'h02);
    send(8'h11);
    gap(TO - 1);
    send(8'h22);
    gap(2);
    chk("edge_err", n_err, 1);
    chk("edge_done", n_done, 3);
    chk("edge_busy", int'(busy), 0);

    // Reset mid-transfer discards the command in progress.
    send(8'h01);
    for (int i = 0; i < 5; i++) begin
      expect_wr(i, 8'hE0 + i, 0);
      send(8'(8'hE0 + i));
    end
    gap(2);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr", int'(ram_wr), 0);
    gap(2);
    rst_n = 1'b1;
    chk("rst_q", exp_q.size(), 0);
    expect_wr(12'h010, 8'h77, 1);
    send(8'h02); send(8'h00); send(8'h10);
    send(8'h00); send(8'h01); send(8'h77);
    gap(TO + 5);
    chk("post_rst_done", n_done, 4);
    chk("post_rst_err", n_err, 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("final_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
